// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the requester drives start and the
// operands, and the adder returns the busy/done handshake and the result.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-wide ripple slice per clock with a
// registered carry. WIDTH must be a multiple of DIGIT.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT:0]   w_slice;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_s_top;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_slice = {1'b0, r_op_a[DIGIT-1:0]} + {1'b0, r_op_b[DIGIT-1:0]}
                 + (DIGIT+1)'(r_carry);

  // Carry into the top bit of the slice, recovered from its sum bit.
  assign w_c_msb = w_slice[DIGIT-1] ^ r_op_a[DIGIT-1] ^ r_op_b[DIGIT-1];

  assign w_s_top    = WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT);
  assign w_acc_next = (r_acc >> DIGIT) | w_s_top;
  assign w_last     = (r_cnt == CW'(STEPS - 1));

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_op_a  <= r_op_a >> DIGIT;
          r_op_b  <= r_op_b >> DIGIT;
          r_acc   <= w_acc_next;
          r_carry <= w_slice[DIGIT];
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_slice[DIGIT];
            r_ovf   <= w_c_msb ^ w_slice[DIGIT];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table on the 16/1 build,
// handshake and reset corner cases, then a lock-step sweep of four builds.
module tb_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   e0 = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  serial_adder_if #(.WIDTH(16)) if0 ();
  serial_adder_if #(.WIDTH(16)) if4 ();
  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(1))  if1 ();

  serial_adder #(.WIDTH(16), .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_adder #(.WIDTH(8),  .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(1),  .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // NOTE: outputs are sampled 1 time unit after the rising edge, so the DUT's
  // non-blocking updates have settled and nothing races the clock.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent arithmetic model: full-width add, carry into MSB from the
  // low WIDTH-1 bits.
  function automatic res_t model(input int w, input logic [15:0] a, b,
                                 input logic cin, sub);
    logic [16:0] mask, lmask, aa, bb, full, low;
    logic        c0, cmsb;
    res_t        r;
    mask  = (17'd1 << w) - 17'd1;
    lmask = (17'd1 << (w - 1)) - 17'd1;
    aa    = {1'b0, a} & mask;
    bb    = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    c0    = sub ? 1'b1 : cin;
    full  = aa + bb + 17'(c0);
    low   = (aa & lmask) + (bb & lmask) + 17'(c0);
    cmsb  = low[w-1];
    r.sum  = full[15:0] & mask[15:0];
    r.cout = full[w];
    r.ovf  = cmsb ^ full[w];
    return r;
  endfunction

  task automatic start_op(input logic [15:0] a, b, input logic cin, sub);
    if0.a = a; if0.b = b; if0.cin = cin; if0.sub = sub; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    e0 = cyc;
    if0.a   = 16'($urandom);
    if0.b   = 16'($urandom);
    if0.cin = 1'($urandom_range(0, 1));
    if0.sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    int guard = 0;
    busy_n = 0;
    while (!if0.done && guard < 100) begin
      if (if0.busy) busy_n++;
      tick();
      guard++;
    end
    check("done_timeout", 32'(if0.done), 32'd1);
    check("busy_with_done", 32'(if0.busy), 32'd0);
    lat = cyc - e0;
  endtask

  vec_t vecs[9];

  initial begin
    int lat, bn;
    logic seen_done;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    if0.start = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0; if0.sub = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.sub = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.sub = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_done", 32'(if0.done), 32'd0);
    check("rst_sum", 32'(if0.sum), 32'd0);
    check("rst_cout", 32'(if0.cout), 32'd0);
    check("rst_ovf", 32'(if0.overflow), 32'd0);
    check("rst_sum4", 32'(if4.sum), 32'd0);
    check("rst_sum8", 32'(if8.sum), 32'd0);
    check("rst_busy1", 32'(if1.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done(lat, bn);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd16);
      check($sformatf("vec%0d_busy", i), 32'(bn), 32'd16);
      check($sformatf("vec%0d_sum", i), 32'(if0.sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(if0.cout), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_ovf", i), 32'(if0.overflow), 32'(vecs[i].exp_ovf));
      tick();
      check($sformatf("vec%0d_pulse", i), 32'(if0.done), 32'd0);
      check($sformatf("vec%0d_hold", i), 32'(if0.sum), 32'(vecs[i].exp_sum));
    end

    // start during RUN is ignored
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    repeat (5) tick();
    if0.a = 16'hFFFF; if0.b = 16'hFFFF; if0.sub = 1'b1; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    wait_done(lat, bn);
    check("midrun_lat", 32'(lat), 32'd16);
    check("midrun_sum", 32'(if0.sum), 32'h5555);
    check("midrun_cout", 32'(if0.cout), 32'd0);

    // Back-to-back start in the done cycle; old result holds until new done
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("b2b_busy", 32'(if0.busy), 32'd1);
    check("b2b_done", 32'(if0.done), 32'd0);
    check("b2b_hold0", 32'(if0.sum), 32'h5555);
    repeat (8) tick();
    check("b2b_hold8", 32'(if0.sum), 32'h5555);
    check("b2b_cout_hold", 32'(if0.cout), 32'd0);
    wait_done(lat, bn);
    check("b2b_lat", 32'(lat), 32'd16);
    check("b2b_sum", 32'(if0.sum), 32'h0000);
    check("b2b_cout", 32'(if0.cout), 32'd1);
    tick();

    // Reset mid-operation
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(if0.busy), 32'd0);
    check("abort_done", 32'(if0.done), 32'd0);
    check("abort_sum", 32'(if0.sum), 32'd0);
    check("abort_cout", 32'(if0.cout), 32'd0);
    check("abort_ovf", 32'(if0.overflow), 32'd0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      tick();
      seen_done |= if0.done;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(lat, bn);
    check("after_abort_lat", 32'(lat), 32'd16);
    check("after_abort_sum", 32'(if0.sum), 32'h8000);
    check("after_abort_ovf", 32'(if0.overflow), 32'd1);
    tick();

    // Lock-step sweep over the four builds; first 16 vectors enumerate the 1-bit build
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      logic [3:0]  seen;
      int          lats[4];
      res_t        got[4];
      res_t        exp;
      int          guard;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (i < 16) begin
        ra[0] = i[0]; rb[0] = i[1]; rc = i[2]; rs = i[3];
      end
      if0.a = ra;      if0.b = rb;      if0.cin = rc; if0.sub = rs; if0.start = 1'b1;
      if4.a = ra;      if4.b = rb;      if4.cin = rc; if4.sub = rs; if4.start = 1'b1;
      if8.a = ra[7:0]; if8.b = rb[7:0]; if8.cin = rc; if8.sub = rs; if8.start = 1'b1;
      if1.a = ra[0];   if1.b = rb[0];   if1.cin = rc; if1.sub = rs; if1.start = 1'b1;
      tick();
      e0 = cyc;
      if0.start = 1'b0; if4.start = 1'b0; if8.start = 1'b0; if1.start = 1'b0;
      seen = '0;
      guard = 0;
      while (seen != 4'hF && guard < 40) begin
        tick();
        guard++;
        if (!seen[0] && if0.done) begin seen[0] = 1'b1; lats[0] = cyc - e0; got[0] = '{if0.sum, if0.cout, if0.overflow}; end
        if (!seen[1] && if4.done) begin seen[1] = 1'b1; lats[1] = cyc - e0; got[1] = '{if4.sum, if4.cout, if4.overflow}; end
        if (!seen[2] && if8.done) begin seen[2] = 1'b1; lats[2] = cyc - e0; got[2] = '{16'(if8.sum), if8.cout, if8.overflow}; end
        if (!seen[3] && if1.done) begin seen[3] = 1'b1; lats[3] = cyc - e0; got[3] = '{16'(if1.sum), if1.cout, if1.overflow}; end
      end
      check("sweep_done_all", 32'(seen), 32'hF);
      if (seen == 4'hF) begin
        check("lat_16_1", 32'(lats[0]), 32'd16);
        check("lat_16_4", 32'(lats[1]), 32'd4);
        check("lat_8_8", 32'(lats[2]), 32'd1);
        check("lat_1_1", 32'(lats[3]), 32'd1);
        exp = model(16, ra, rb, rc, rs);
        check("res_16_1", {15'd0, got[0].ovf, got[0].cout, got[0].sum}, {15'd0, exp.ovf, exp.cout, exp.sum});
        check("res_16_4", {15'd0, got[1].ovf, got[1].cout, got[1].sum}, {15'd0, exp.ovf, exp.cout, exp.sum});
        exp = model(8, ra, rb, rc, rs);
        check("res_8_8", {15'd0, got[2].ovf, got[2].cout, got[2].sum}, {15'd0, exp.ovf, exp.cout, exp.sum});
        if (!rs) begin
          // Full-adder truth table; for one bit the carry into the MSB is cin.
          check("fa_sum", 32'(got[3].sum), 32'(ra[0] ^ rb[0] ^ rc));
          check("fa_cout", 32'(got[3].cout), 32'((ra[0] & rb[0]) | (ra[0] & rc) | (rb[0] & rc)));
          check("fa_ovf", 32'(got[3].ovf), 32'(rc ^ ((ra[0] & rb[0]) | (ra[0] & rc) | (rb[0] & rc))));
        end else begin
          exp = model(1, ra, rb, rc, rs);
          check("res_1_1", {15'd0, got[3].ovf, got[3].cout, got[3].sum}, {15'd0, exp.ovf, exp.cout, exp.sum});
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
